key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Conditions the raw active-low DE2 push-button inputs before they reach the Nios II push-button PIO.
- Per key: 2-flop synchronizer, then a counter-based debounce FSM. Outputs a clean active-high pressed level, a one-cycle press pulse, and a sticky press-event flag.
- Software clears the sticky flag through a clear mask. The block sits directly upstream of the SoC push_button/event PIO inputs in the top level.

Parameters:
- NUM_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, cycles an input must stay stable before a transition is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  synchronous reset, active low.
- key_n  in  NUM_KEYS  raw asynchronous key pins, 0 = pressed.
- evt_clr  in  NUM_KEYS  per-key clear of the sticky event, sampled each cycle.
- pressed  out  NUM_KEYS  debounced level, 1 = held.
- press_pulse  out  NUM_KEYS  one-cycle pulse on an accepted press.
- press_evt  out  NUM_KEYS  sticky flag, set on an accepted press, held until cleared.

Behaviour:
- Reset: all channels are synchronous, active-low on Reset_n, sampled on the rising edge of Clk.
  - Reset values: synchronizer flops = 1 (released), counter = 0, FSM = RELEASED, pressed = 0, press_pulse = 0, press_evt = 0.
- Synchronizer: two flops per key, then invert, giving s = ~key_n after 2 cycles. No logic acts on the first flop.
- FSM per channel:
  - RELEASED: pressed = 0. If s = 1, go to WAIT_PRESS with cnt = 1.
  - WAIT_PRESS: if s = 0, return to RELEASED with cnt = 0 (glitch rejected). Else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED and assert press_pulse for that cycle. Else cnt++.
  - PRESSED: pressed = 1. If s = 0, go to WAIT_RELEASE with cnt = 1.
  - WAIT_RELEASE: pressed stays 1. If s = 1, return to PRESSED with cnt = 0. Else if cnt = DEBOUNCE_CYCLES-1, go to RELEASED (no pulse). Else cnt++.
- Latency:
  - Clean edge on key_n to pressed rising: 2 + DEBOUNCE_CYCLES cycles.
  - press_pulse is registered and is high in the same cycle pressed first reads 1.
  - Release latency is identical.
- press_pulse: exactly one cycle per accepted press. Never asserted on release or on a rejected glitch.
- press_evt: next = (press_evt & ~evt_clr) | press_pulse.
  - A simultaneous pulse and clear on the same key leaves the flag SET; the press wins and no event is lost.
  - Clearing a flag that is already 0 has no effect.
- Counter: saturates by construction (terminal compare). It never wraps, and it never exceeds DEBOUNCE_CYCLES-1.
- Channels are fully independent. Simultaneous presses on all keys each produce their own pulse and flag in the same cycle.
- Reset mid-debounce: the channel returns to RELEASED immediately. A key still held after reset must re-qualify for the full DEBOUNCE_CYCLES and then yields a fresh pulse.
- Key held through reset deassertion: treated as a new press after 2 + DEBOUNCE_CYCLES cycles.

Decomposition:
- Shared package key_debounce_pkg holds:
  - the enum typedef for the 4 FSM states (RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE);
  - the default DEBOUNCE_CYCLES constant for 50 MHz.
- Sub-module debounce_channel:
  - contains the 1-bit synchronizer, FSM, counter and sticky flag;
  - instantiated as an array of NUM_KEYS in key_debounce;
  - the top is pure wiring.

Test Plan (DEBOUNCE_CYCLES = 8 for simulation):
- Clean press: key_n[0] goes 1→0 at cycle 0 and is held → pressed[0] = 1 and press_pulse[0] = 1 at cycle 10 only. press_evt[0] = 1 from cycle 11 onward. key 1 untouched.
- Bounce rejection: key_n[0] low for 5 cycles, high for 1, low for 3, then high → pressed, press_pulse and press_evt stay 0 throughout.
- Bouncy press then clean hold: bounce pattern followed by a 20-cycle hold → exactly one press_pulse, 10 cycles after the last low-going edge.
- Release: after the press above, key_n[0] returns to 1 → pressed[0] falls 10 cycles later, no pulse, press_evt[0] remains 1.
- Clear race: assert evt_clr[1] in the same cycle press_pulse[1] fires → press_evt[1] stays 1. A later evt_clr[1] alone clears it to 0 next cycle.
- Reset mid-operation: Reset_n low for 1 cycle during WAIT_PRESS (cnt = 5) with key still held → all outputs 0 the next cycle. press_pulse then fires 10 cycles after Reset_n returns high.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debounce block.
// The channel FSM states and the default qualification time at 50 MHz.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } deb_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 500000;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchronizer, counter-qualified debounce FSM,
// registered press pulse and a software-clearable sticky press flag.
//
// state        | meaning
// RELEASED     | key idle, pressed = 0
// WAIT_PRESS   | key seen down, counting stable-down cycles
// PRESSED      | press accepted, pressed = 1
// WAIT_RELEASE | key seen up, counting stable-up cycles, pressed still 1
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic key_n,
  input  logic evt_clr,
  output logic pressed,
  output logic press_pulse,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             evt_q, evt_d;
  logic             s;

  // Only the second flop feeds logic; the first is purely for metastability.
  assign sync_d = {sync_q[0], key_n};
  assign s      = ~sync_q[1];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_q  <= 2'b11;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      evt_q   <= evt_d;
    end
  end

  // Terminal-count compare keeps the counter from ever passing CNT_TC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // A pulse landing together with a clear keeps the flag set.
  always_comb begin
    pulse_d = (state_q == WAIT_PRESS) && s && (cnt_q == CNT_TC);
    evt_d   = (evt_q & ~evt_clr) | pulse_q;
    pressed = (state_q == PRESSED) || (state_q == WAIT_RELEASE);
  end

  assign press_pulse = pulse_q;
  assign press_evt   = evt_q;

endmodule

// File: rtl/key_debounce.sv
// Debounce front end for the active-low board push-buttons feeding the
// push-button / event PIO; one independent channel per key.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] evt_clr,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] press_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .key_n       (key_n[g]),
      .evt_clr     (evt_clr[g]),
      .pressed     (pressed[g]),
      .press_pulse (press_pulse[g]),
      .press_evt   (press_evt[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with an 8-cycle qualification time:
// directed scenarios against fixed timings plus randomized keys against a stability-run model.
module tb_key_debounce;

  localparam int NK = 2;
  localparam int DC = 8;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] evt_clr = '0;
  logic [NK-1:0] pressed, press_pulse, press_evt;

  int errors = 0;
  int checks = 0;

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .key_n       (key_n),
    .evt_clr     (evt_clr),
    .pressed     (pressed),
    .press_pulse (press_pulse),
    .press_evt   (press_evt)
  );

  always #5 Clk = ~Clk;

  // Reference: the key value seen two edges late; a level change is accepted once
  // the seen value has differed from the accepted level for DC consecutive edges.
  logic          m_k1 [NK];
  logic          m_k2 [NK];
  int            m_run [NK];
  logic [NK-1:0] m_pressed = '0;
  logic [NK-1:0] m_pulse = '0;
  logic [NK-1:0] m_evt = '0;

  initial begin
    for (int i = 0; i < NK; i++) begin
      m_k1[i] = 1'b1;
      m_k2[i] = 1'b1;
      m_run[i] = 0;
    end
  end

  always @(posedge Clk) begin : model
    logic [NK-1:0] pulse_prev;
    logic seen;
    pulse_prev = m_pulse;
    for (int i = 0; i < NK; i++) begin
      if (!Reset_n) begin
        m_k1[i] = 1'b1;
        m_k2[i] = 1'b1;
        m_run[i] = 0;
        m_pressed[i] = 1'b0;
        m_pulse[i] = 1'b0;
        m_evt[i] = 1'b0;
      end else begin
        seen = ~m_k2[i];
        m_k2[i] = m_k1[i];
        m_k1[i] = key_n[i];
        m_evt[i] = (m_evt[i] & ~evt_clr[i]) | pulse_prev[i];
        m_pulse[i] = 1'b0;
        if (seen != m_pressed[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            m_pressed[i] = seen;
            m_pulse[i] = seen;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  task automatic settle();
    key_n = '1;
    evt_clr = '0;
    repeat (2 * DC + 4) @(negedge Clk);
    evt_clr = '1;
    @(negedge Clk);
    evt_clr = '0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({pressed, press_pulse, press_evt} !== '0) begin
      errors++;
      $display("FAIL reset_held got=%b exp=0", {pressed, press_pulse, press_evt});
    end
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({pressed, press_pulse, press_evt} !== '0) begin
      errors++;
      $display("FAIL reset_released got=%b exp=0", {pressed, press_pulse, press_evt});
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] exp;
    key_n[0] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      exp = {c >= 10, c == 10, c >= 11, 3'b000};
      checks++;
      if ({pressed[0], press_pulse[0], press_evt[0], pressed[1], press_pulse[1], press_evt[1]} !== exp) begin
        errors++;
        $display("FAIL clean_press c=%0d got=%b exp=%b", c,
                 {pressed[0], press_pulse[0], press_evt[0], pressed[1], press_pulse[1], press_evt[1]}, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] exp;
    key_n[0] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      exp = {c < 10, 1'b0, 1'b1};
      checks++;
      if ({pressed[0], press_pulse[0], press_evt[0]} !== exp) begin
        errors++;
        $display("FAIL release c=%0d got=%b exp=%b", c, {pressed[0], press_pulse[0], press_evt[0]}, exp);
      end
    end
    evt_clr[0] = 1'b1;
    @(negedge Clk);
    evt_clr[0] = 1'b0;
    checks++;
    if (press_evt[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_evt0 got=%b exp=0", press_evt[0]);
    end
  endtask

  task automatic test_bounce();
    logic pat [29];
    for (int i = 0; i < 29; i++) pat[i] = !((i < 5) || (i >= 6 && i < 9));
    for (int c = 0; c < 29; c++) begin
      key_n[0] = pat[c];
      @(negedge Clk);
      checks++;
      if ({pressed[0], press_pulse[0], press_evt[0]} !== 3'b000) begin
        errors++;
        $display("FAIL bounce c=%0d got=%b exp=000", c, {pressed[0], press_pulse[0], press_evt[0]});
      end
    end
  endtask

  task automatic test_bouncy_hold();
    logic pat [40];
    int npulse;
    npulse = 0;
    for (int i = 0; i < 40; i++) pat[i] = (i == 5) || (i == 9);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        if (press_pulse[0]) npulse++;
        checks++;
        if (press_pulse[0] !== (c == 20)) begin
          errors++;
          $display("FAIL bouncy_hold_pulse c=%0d got=%b exp=%b", c, press_pulse[0], c == 20);
        end
      end
      key_n[0] = pat[c];
      @(negedge Clk);
    end
    checks++;
    if (npulse != 1 || press_evt[0] !== 1'b1) begin
      errors++;
      $display("FAIL bouncy_hold_count got=%0d/%b exp=1/1", npulse, press_evt[0]);
    end
  endtask

  task automatic test_clear_race();
    logic [2:0] exp;
    key_n[1] = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge Clk);
      exp = {c >= 10, c == 10, (c >= 11) && (c < 13)};
      checks++;
      if ({pressed[1], press_pulse[1], press_evt[1]} !== exp) begin
        errors++;
        $display("FAIL clear_race c=%0d got=%b exp=%b", c, {pressed[1], press_pulse[1], press_evt[1]}, exp);
      end
      evt_clr[1] = (c == 10) || (c == 12);
    end
    evt_clr[1] = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    key_n = '0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      exp = {{2{c >= 10}}, {2{c == 10}}, {2{c >= 11}}};
      checks++;
      if ({pressed, press_pulse, press_evt} !== exp) begin
        errors++;
        $display("FAIL simultaneous c=%0d got=%b exp=%b", c, {pressed, press_pulse, press_evt}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    key_n[0] = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge Clk);
      exp = {1'b0, c >= 18, 1'b0, c == 18, 1'b0, c >= 19};
      checks++;
      if ({pressed, press_pulse, press_evt} !== exp) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, {pressed, press_pulse, press_evt}, exp);
      end
      Reset_n = (c != 7);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clk);
      checks++;
      if ({pressed, press_pulse, press_evt} !== {m_pressed, m_pulse, m_evt}) begin
        errors++;
        $display("FAIL random c=%0d got=%b exp=%b", c, {pressed, press_pulse, press_evt},
                 {m_pressed, m_pulse, m_evt});
      end
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 9) == 0) key_n[i] = ~key_n[i];
        evt_clr[i] = ($urandom_range(0, 11) == 0);
      end
      Reset_n = ($urandom_range(0, 299) != 0);
    end
    Reset_n = 1'b1;
    evt_clr = '0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    settle();
    test_bounce();
    settle();
    test_bouncy_hold();
    settle();
    test_clear_race();
    settle();
    test_simultaneous();
    settle();
    test_reset_mid();
    settle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
